// File: rtl/hash_pkg.sv
// rtl/hash_pkg.sv - constants, FSM encoding and word helpers for the iterative round hash
package hash_pkg;

    localparam int MAX_W = 64;
    typedef logic [MAX_W-1:0] word_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_ROUND,
        S_DONE
    } state_t;

    // Stored 32 bits wide; each core truncates (or zero-extends) to its WORD_W.
    localparam logic [31:0] IV32 [4] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a
    };

    localparam logic [31:0] K32 [16] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174
    };

    function automatic word_t wmask(input int w);
        return (w >= MAX_W) ? '1 : ((word_t'(1) << w) - word_t'(1));
    endfunction

    function automatic word_t rotl(input word_t x, input int n, input int w);
        word_t xm;
        xm = x & wmask(w);
        return ((xm << n) | (xm >> (w - n))) & wmask(w);
    endfunction

    function automatic word_t sig(input word_t x, input int w);
        return (rotl(x, 2, w) ^ rotl(x, 7, w) ^ ((x & wmask(w)) >> 3)) & wmask(w);
    endfunction

    function automatic word_t s0(input word_t x, input int w);
        return (rotl(x, 5, w) + rotl(x, 11, w)) & wmask(w);
    endfunction

    function automatic word_t s1(input word_t x, input int w);
        return (rotl(x, 2, w) + rotl(x, 7, w)) & wmask(w);
    endfunction

endpackage

// File: rtl/hash_round_step.sv
// rtl/hash_round_step.sv - one combinational compression round
module hash_round_step
    import hash_pkg::*;
#(
    parameter int WORD_W = 16
) (
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic [WORD_W-1:0] c,
    input  logic [WORD_W-1:0] d,
    input  logic [WORD_W-1:0] k,
    input  logic [WORD_W-1:0] w,
    output logic [WORD_W-1:0] a_nxt,
    output logic [WORD_W-1:0] b_nxt,
    output logic [WORD_W-1:0] c_nxt,
    output logic [WORD_W-1:0] d_nxt
);

    logic [WORD_W-1:0] ch;
    logic [WORD_W-1:0] maj;
    logic [WORD_W-1:0] t1;
    logic [WORD_W-1:0] t2;

    assign ch  = (b & c) | (~b & d);
    assign maj = (a & b) | (b & c) | (c & a);
    assign t1  = WORD_W'(s1(word_t'(c), WORD_W)) ^ ch ^ (d & k) ^ w;
    assign t2  = maj | WORD_W'(s0(word_t'(a), WORD_W));

    assign a_nxt = t1 + t2;
    assign b_nxt = a;
    assign c_nxt = b;
    assign d_nxt = c + t1;

endmodule

// File: rtl/hash_iter_core.sv
// rtl/hash_iter_core.sv - iterative round hash core, one round per clock; HASH_FEEDFWD_EN adds IV to the digest
module hash_iter_core
    import hash_pkg::*;
#(
    parameter int WORD_W    = 16,
    parameter int MSG_BYTES = 6,
    parameter int ROUNDS    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [8*MSG_BYTES-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*WORD_W-1:0]    out_digest,
    output logic                   busy
);

    localparam int NM = MSG_BYTES * 8 / WORD_W;
    localparam int RW = 5;
    localparam logic [WORD_W-1:0] IV0 = WORD_W'(IV32[0]);
    localparam logic [WORD_W-1:0] IV1 = WORD_W'(IV32[1]);
    localparam logic [WORD_W-1:0] IV2 = WORD_W'(IV32[2]);
    localparam logic [WORD_W-1:0] IV3 = WORD_W'(IV32[3]);

    state_t                 state;
    state_t                 state_nxt;
    logic                   alive;
    logic [8*MSG_BYTES-1:0] msg;
    logic [WORD_W-1:0]      cnt;
    logic [WORD_W-1:0]      cnt_nxt;
    logic [WORD_W-1:0]      a, b, c, d;
    logic [WORD_W-1:0]      a_n, b_n, c_n, d_n;
    logic [WORD_W-1:0]      w1, w2, w3;
    logic [WORD_W-1:0]      w_msg;
    logic [WORD_W-1:0]      w_cur;
    logic [WORD_W-1:0]      k_cur;
    logic [RW-1:0]          rnd;
    logic [4*WORD_W-1:0]    digest_q;
    logic                   last_round;

    assign last_round = (rnd == RW'(ROUNDS - 1));
    assign k_cur      = WORD_W'(K32[rnd[3:0]]);
    assign out_digest = digest_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (in_valid && in_ready) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_ROUND;
            S_ROUND: if (last_round) state_nxt = S_DONE;
            S_DONE:  if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // alive keeps in_ready low while reset is held, even though state already reads IDLE.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state)
            S_IDLE:          in_ready  = alive;
            S_LOAD, S_ROUND: busy      = 1'b1;
            S_DONE:          out_valid = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < MSG_BYTES; i++) begin
            if (msg[8*i +: 8] != 8'h00) cnt_nxt = cnt_nxt + WORD_W'(1);
        end
    end

    // Message words first, then the nonzero-byte count, then the expanded schedule.
    always_comb begin
        w_msg = cnt;
        for (int i = 0; i < NM; i++) begin
            if (int'(rnd) == i) w_msg = msg[8*MSG_BYTES-1 - i*WORD_W -: WORD_W];
        end
        if (int'(rnd) <= NM) begin
            w_cur = w_msg;
        end else begin
            w_cur = WORD_W'(sig(word_t'(w3), WORD_W)) + w1;
        end
    end

    hash_round_step #(.WORD_W(WORD_W)) u_step (
        .a     (a),
        .b     (b),
        .c     (c),
        .d     (d),
        .k     (k_cur),
        .w     (w_cur),
        .a_nxt (a_n),
        .b_nxt (b_n),
        .c_nxt (c_n),
        .d_nxt (d_n)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alive    <= 1'b0;
            msg      <= '0;
            cnt      <= '0;
            a        <= IV0;
            b        <= IV1;
            c        <= IV2;
            d        <= IV3;
            w1       <= '0;
            w2       <= '0;
            w3       <= '0;
            rnd      <= '0;
            digest_q <= '0;
        end else begin
            alive <= 1'b1;
            unique case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) msg <= in_data;
                end
                S_LOAD: begin
                    cnt <= cnt_nxt;
                    a   <= IV0;
                    b   <= IV1;
                    c   <= IV2;
                    d   <= IV3;
                    w1  <= '0;
                    w2  <= '0;
                    w3  <= '0;
                    rnd <= '0;
                end
                S_ROUND: begin
                    a   <= a_n;
                    b   <= b_n;
                    c   <= c_n;
                    d   <= d_n;
                    w1  <= w_cur;
                    w2  <= w1;
                    w3  <= w2;
                    rnd <= rnd + RW'(1);
                    if (last_round) begin
`ifdef HASH_FEEDFWD_EN
                        digest_q <= {a_n + IV0, b_n + IV1, c_n + IV2, d_n + IV3};
`else
                        digest_q <= {a_n, b_n, c_n, d_n};
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hash_iter_core.sv
// tb/tb_hash_iter_core.sv - directed self-checking bench for hash_iter_core (default and 32-bit builds)
module tb_hash_iter_core;

`ifdef HASH_FEEDFWD_EN
    localparam bit FF = 1'b1;
`else
    localparam bit FF = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid16, in_ready16, out_valid16, out_ready16, busy16;
    logic [47:0]  in_data16;
    logic [63:0]  out_digest16;
    logic         in_valid32, in_ready32, out_valid32, out_ready32, busy32;
    logic [63:0]  in_data32;
    logic [127:0] out_digest32;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0]  tb_iv [4] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a};
    logic [31:0]  tb_k [16] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174};
    logic [63:0]  mdl_w [16];
    logic [15:0]  cap_w [8];

    always #5 clk = ~clk;

    hash_iter_core u16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .in_data(in_data16), .out_valid(out_valid16), .out_ready(out_ready16),
        .out_digest(out_digest16), .busy(busy16)
    );

    hash_iter_core #(.WORD_W(32), .MSG_BYTES(8), .ROUNDS(12)) u32 (
        .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
        .in_data(in_data32), .out_valid(out_valid32), .out_ready(out_ready32),
        .out_digest(out_digest32), .busy(busy32)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] msk_of(input int ww);
        return (ww >= 64) ? '1 : ((64'd1 << ww) - 64'd1);
    endfunction

    function automatic logic [63:0] rl(input logic [63:0] x, input int n, input int ww);
        return ((x << n) | (x >> (ww - n))) & msk_of(ww);
    endfunction

    function automatic logic [63:0] sg(input logic [63:0] x, input int ww);
        return rl(x, 2, ww) ^ rl(x, 7, ww) ^ (x >> 3);
    endfunction

    task automatic run_model(input logic [63:0] data, input int ww, input int nb, input int rounds,
                             input bit ff, output logic [127:0] dig);
        logic [63:0] msk, a, b, c, d, t1, t2, s0a, s1c, ch, mj, na, nd;
        logic [63:0] m [10];
        int nm, cnt;
        msk = msk_of(ww);
        nm  = nb * 8 / ww;
        cnt = 0;
        for (int i = 0; i < nb; i++) if (((data >> (8*i)) & 64'hff) != 64'd0) cnt++;
        for (int i = 0; i < nm; i++) m[i] = (data >> (nb*8 - (i+1)*ww)) & msk;
        m[nm] = 64'(cnt);
        for (int t = 0; t < rounds; t++) begin
            if (t <= nm) mdl_w[t] = m[t];
            else         mdl_w[t] = (sg(mdl_w[t-3], ww) + mdl_w[t-1]) & msk;
        end
        a = {32'd0, tb_iv[0]} & msk;
        b = {32'd0, tb_iv[1]} & msk;
        c = {32'd0, tb_iv[2]} & msk;
        d = {32'd0, tb_iv[3]} & msk;
        for (int t = 0; t < rounds; t++) begin
            s1c = (rl(c, 2, ww) + rl(c, 7, ww)) & msk;
            s0a = (rl(a, 5, ww) + rl(a, 11, ww)) & msk;
            ch  = ((b & c) | (~b & d)) & msk;
            mj  = (a & b) | (b & c) | (c & a);
            t1  = (s1c ^ ch ^ (d & {32'd0, tb_k[t]}) ^ mdl_w[t]) & msk;
            t2  = mj | s0a;
            na  = (t1 + t2) & msk;
            nd  = (c + t1) & msk;
            d = nd; c = b; b = a; a = na;
        end
        if (ff) begin
            a = (a + {32'd0, tb_iv[0]}) & msk;
            b = (b + {32'd0, tb_iv[1]}) & msk;
            c = (c + {32'd0, tb_iv[2]}) & msk;
            d = (d + {32'd0, tb_iv[3]}) & msk;
        end
        dig = (128'(a) << (3*ww)) | (128'(b) << (2*ww)) | (128'(c) << ww) | 128'(d);
    endtask

    task automatic xact16(input string tg, input logic [47:0] data, input bit early, output logic [63:0] dig);
        int n;
        n = 0;
        while (!in_ready16 && n < 40) begin @(negedge clk); n++; end
        check({tg, "_rdy"}, 128'(in_ready16), 128'd1);
        in_data16 = data; in_valid16 = 1'b1; out_ready16 = early;
        @(negedge clk);
        in_valid16 = 1'b0; in_data16 = '0;
        n = 0;
        while (!out_valid16 && n < 40) begin
            @(negedge clk);
            n++;
            if (n <= 8) cap_w[n-1] = u16.w_cur;
        end
        check({tg, "_lat"}, 128'(n), 128'd9);
        dig = out_digest16;
    endtask

    task automatic xact32(input string tg, input logic [63:0] data, output logic [127:0] dig);
        int n;
        n = 0;
        while (!in_ready32 && n < 40) begin @(negedge clk); n++; end
        check({tg, "_rdy"}, 128'(in_ready32), 128'd1);
        in_data32 = data; in_valid32 = 1'b1;
        @(negedge clk);
        in_valid32 = 1'b0; in_data32 = '0;
        n = 0;
        while (!out_valid32 && n < 40) begin @(negedge clk); n++; end
        check({tg, "_lat"}, 128'(n), 128'd13);
        dig = out_digest32;
        out_ready32 = 1'b1;
        @(negedge clk);
        out_ready32 = 1'b0;
        check({tg, "_idle"}, 128'(in_ready32), 128'd1);
    endtask

    task automatic release16(input string tg);
        out_ready16 = 1'b1;
        @(negedge clk);
        out_ready16 = 1'b0;
        check({tg, "_rel_rdy"}, 128'(in_ready16), 128'd1);
        check({tg, "_rel_vld"}, 128'(out_valid16), 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [127:0] exp, raw;
        logic [63:0]  got16;
        logic [127:0] got32;

        rst = 1'b1;
        in_valid16 = 1'b0; out_ready16 = 1'b0; in_data16 = '0;
        in_valid32 = 1'b0; out_ready32 = 1'b0; in_data32 = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 128'(in_ready16), 128'd0);
        check("rst_out_valid", 128'(out_valid16), 128'd0);
        check("rst_busy", 128'(busy16), 128'd0);
        check("rst_digest", 128'(out_digest16), 128'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 128'(in_ready16), 128'd1);

        // all-zero message, out_ready held high early (ignored until DONE)
        run_model(64'h0, 16, 6, 8, FF, exp);
        xact16("t1", 48'h0, 1'b1, got16);
        check("t1_count_word", 128'(cap_w[3]), 128'd0);
        check("t1_digest", 128'(got16), exp);
        @(negedge clk);
        out_ready16 = 1'b0;
        check("t1_idle_rdy", 128'(in_ready16), 128'd1);

        // byte ordering of message words, consumer stall in DONE
        run_model(64'h010203040506, 16, 6, 8, FF, exp);
        xact16("t2", 48'h010203040506, 1'b0, got16);
        check("t2_m0", 128'(cap_w[0]), 128'h0102);
        check("t2_m1", 128'(cap_w[1]), 128'h0304);
        check("t2_m2", 128'(cap_w[2]), 128'h0506);
        check("t2_m3", 128'(cap_w[3]), 128'h0006);
        check("t2_digest", 128'(got16), exp);
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_digest", 128'(out_digest16), exp);
            check("t2_hold_rdy", 128'(in_ready16), 128'd0);
            check("t2_hold_vld", 128'(out_valid16), 128'd1);
            @(negedge clk);
        end
        release16("t2");

        // count word and expanded schedule
        run_model(64'h00FF0000AB00, 16, 6, 8, FF, exp);
        xact16("t3", 48'h00FF0000AB00, 1'b0, got16);
        check("t3_count_word", 128'(cap_w[3]), 128'd2);
        for (int t = 4; t < 8; t++) check($sformatf("t3_w%0d", t), 128'(cap_w[t]), 128'(mdl_w[t][15:0]));
        check("t3_digest", 128'(got16), exp);
        release16("t3");

        // reset three cycles into ROUND aborts the operation
        in_data16 = 48'h112233445566; in_valid16 = 1'b1;
        @(negedge clk);
        in_valid16 = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_busy_before", 128'(busy16), 128'd1);
        rst = 1'b1;
        #1;
        check("abort_out_valid", 128'(out_valid16), 128'd0);
        check("abort_busy", 128'(busy16), 128'd0);
        check("abort_in_ready", 128'(in_ready16), 128'd0);
        check("abort_digest", 128'(out_digest16), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_rel_ready", 128'(in_ready16), 128'd1);
        run_model(64'h0A0B0C0D0E0F, 16, 6, 8, FF, exp);
        xact16("t5", 48'h0A0B0C0D0E0F, 1'b0, got16);
        check("t5_digest", 128'(got16), exp);
        release16("t5");

        // wide build: 32-bit words, 8-byte message, 12 rounds
        run_model(64'h0123456789ABCDEF, 32, 8, 12, FF, exp);
        xact32("t6", 64'h0123456789ABCDEF, got32);
        check("t6_digest", got32, exp);
`ifdef HASH_FEEDFWD_EN
        run_model(64'h0123456789ABCDEF, 32, 8, 12, 1'b0, raw);
        check("t6_ff_delta", {got32[127:96] - raw[127:96], got32[95:64] - raw[95:64],
                              got32[63:32] - raw[63:32], got32[31:0] - raw[31:0]},
              {tb_iv[0], tb_iv[1], tb_iv[2], tb_iv[3]});
`else
        raw = '0;
`endif
        run_model(64'h0000112200000033, 32, 8, 12, FF, exp);
        xact32("t7", 64'h0000112200000033, got32);
        check("t7_digest", got32, exp);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
